// File: rtl/l2_port_scheduler_if.sv
// Cache-side and L2-side signal bundle for the shared L2 port scheduler.
// The slave modport is the scheduler; the master modport is the caches plus the L2 model.
interface l2_port_scheduler_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;
  logic              err_proto;
  logic              err_timeout;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
    output i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata,
           err_proto, err_timeout
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata,
           err_proto, err_timeout
  );
endinterface

// File: rtl/l2_port_scheduler.sv
// Round-robin arbiter sharing one L2 line port between the I-cache and D-cache.
// The winning command is latched and held stable until L2 completes the transfer.
module l2_port_scheduler #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned TIMEOUT = 1023
) (
  input logic                clk,
  input logic                rst_n,
  l2_port_scheduler_if.slave bus
);

  localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;

  state_t            state;
  logic              last_d;
  logic              l2_read_q;
  logic              l2_write_q;
  logic [ADDR_W-1:0] l2_addr_q;
  logic [LINE_W-1:0] l2_wdata_q;
  logic              proto_q;
  logic              timeout_q;
  logic [WD_W-1:0]   wd_q;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic owner_req;

  assign i_req     = bus.i_read;
  assign d_req     = bus.d_read | bus.d_write;
  // I wins when alone, or on a tie when D owned the port last
  assign grant_i   = i_req & (~d_req | last_d);
  assign owner_req = (state == BUSY_I) ? i_req : d_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_d     <= 1'b1;
      l2_read_q  <= 1'b0;
      l2_write_q <= 1'b0;
      l2_addr_q  <= '0;
      l2_wdata_q <= '0;
      proto_q    <= 1'b0;
      timeout_q  <= 1'b0;
      wd_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.d_read && bus.d_write) proto_q <= 1'b1;
          if (grant_i) begin
            state      <= BUSY_I;
            last_d     <= 1'b0;
            l2_read_q  <= 1'b1;
            l2_write_q <= 1'b0;
            l2_addr_q  <= bus.i_addr;
            wd_q       <= '0;
          end else if (d_req) begin
            state      <= BUSY_D;
            last_d     <= 1'b1;
            l2_read_q  <= ~bus.d_write;
            l2_write_q <= bus.d_write;
            l2_addr_q  <= bus.d_addr;
            l2_wdata_q <= bus.d_wdata;
            wd_q       <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          // Watchdog only flags; the transfer still waits for l2_resp
          if (TIMEOUT != 0) begin
            if (wd_q != WD_MAX)  wd_q <= wd_q + 1'b1;
            if (wd_q == WD_LAST) timeout_q <= 1'b1;
          end
          if (bus.l2_resp) begin
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            state      <= RELEASE;
          end else if (!owner_req) begin
            proto_q <= 1'b1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.l2_read     = l2_read_q;
  assign bus.l2_write    = l2_write_q;
  assign bus.l2_addr     = l2_addr_q;
  assign bus.l2_wdata    = l2_wdata_q;
  assign bus.err_proto   = proto_q;
  assign bus.err_timeout = timeout_q;

  // Completion is forwarded in the same cycle; rdata is qualified by resp
  assign bus.i_resp  = (state == BUSY_I) & bus.l2_resp;
  assign bus.d_resp  = (state == BUSY_D) & bus.l2_resp;
  assign bus.i_rdata = bus.l2_rdata;
  assign bus.d_rdata = bus.l2_rdata;

endmodule

// File: tb/tb_l2_port_scheduler.sv
// Directed plus randomized bench for l2_port_scheduler against a transaction-level
// round-robin model kept here.
module tb_l2_port_scheduler;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LINE_W  = 256;
  localparam int unsigned TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  l2_port_scheduler_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  l2_port_scheduler #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: pending requests per cache and round-robin memory
  bit          pend_i, pend_d, wr_d, last_d, in_release, o;
  logic [31:0] a_i, a_d;
  logic [255:0] wd_d, exp_wdata, rd;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic apply_req();
    bus.i_read  = pend_i;
    bus.i_addr  = a_i;
    bus.d_read  = pend_d & ~wr_d;
    bus.d_write = pend_d & wr_d;
    bus.d_addr  = a_d;
    bus.d_wdata = wd_d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.l2_resp = 1'b0;
    pend_i = 1'b0; pend_d = 1'b0; last_d = 1'b1; exp_wdata = '0; in_release = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // One complete line transfer: optional new requests, grant, lat wait cycles, response
  task automatic xfer(input bit new_i, input bit new_d, input int lat,
                      input logic [255:0] rdata, output bit owner_d);
    logic [33:0] cmd;
    if (new_i && !pend_i) begin pend_i = 1'b1; a_i = $urandom; end
    if (new_d && !pend_d) begin
      pend_d = 1'b1; a_d = $urandom; wr_d = 1'($urandom_range(0, 1)); wd_d = rnd256();
    end
    apply_req();
    if (in_release) begin
      tick();
      chk("no_grant_in_release", 256'({bus.l2_read, bus.l2_write}), 256'(0));
    end
    tick();
    owner_d = pend_d && (!pend_i || !last_d);
    last_d  = owner_d;
    if (owner_d) exp_wdata = wd_d;
    cmd = owner_d ? {~wr_d, wr_d, a_d} : {1'b1, 1'b0, a_i};
    chk("grant_cmd", 256'({bus.l2_read, bus.l2_write, bus.l2_addr}), 256'(cmd));
    chk("grant_wdata", bus.l2_wdata, exp_wdata);
    for (int c = 0; c < lat; c++) begin
      tick();
      chk("busy_hold_cmd", 256'({bus.l2_read, bus.l2_write, bus.l2_addr}), 256'(cmd));
      chk("busy_no_resp", 256'({bus.i_resp, bus.d_resp}), 256'(0));
    end
    bus.l2_rdata = rdata;
    bus.l2_resp  = 1'b1;
    #1;
    chk("resp_owner", 256'({bus.i_resp, bus.d_resp}), owner_d ? 256'(1) : 256'(2));
    chk("rdata", owner_d ? bus.d_rdata : bus.i_rdata, rdata);
    chk("wdata_hold", bus.l2_wdata, exp_wdata);
    tick();
    bus.l2_resp = 1'b0;
    chk("cmd_cleared", 256'({bus.l2_read, bus.l2_write}), 256'(0));
    chk("no_errors", 256'({bus.err_proto, bus.err_timeout}), 256'(0));
    if (owner_d) pend_d = 1'b0; else pend_i = 1'b0;
    apply_req();
    in_release = 1'b1;
  endtask

  initial begin
    bus.i_read = 1'b0; bus.i_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.l2_rdata = '0; bus.l2_resp = 1'b0;
    a_i = '0; a_d = '0; wd_d = '0; wr_d = 1'b0;

    // Reset held with a pending I read
    rst_n = 1'b0;
    bus.i_read = 1'b1; bus.i_addr = 32'h40;
    tick(); tick();
    chk("rst_l2_cmd", 256'({bus.l2_read, bus.l2_write}), 256'(0));
    chk("rst_resp", 256'({bus.i_resp, bus.d_resp}), 256'(0));
    chk("rst_l2_addr", 256'(bus.l2_addr), 256'(0));
    chk("rst_err", 256'({bus.err_proto, bus.err_timeout}), 256'(0));
    rst_n = 1'b1;
    pend_i = 1'b1; a_i = 32'h40; pend_d = 1'b0; last_d = 1'b1; exp_wdata = '0; in_release = 1'b0;
    xfer(1'b0, 1'b0, 2, rnd256(), o);

    // Single I read with a fixed line
    pend_i = 1'b1; a_i = 32'h60;
    xfer(1'b0, 1'b0, 5, 256'h0200_0063, o);
    chk("single_i_owner", 256'(o), 256'(0));

    // Simultaneous requests after reset: I first, then D two cycles after i_resp
    do_reset();
    pend_i = 1'b1; a_i = 32'h264;
    pend_d = 1'b1; a_d = 32'h80; wr_d = 1'b0; wd_d = rnd256();
    xfer(1'b0, 1'b0, 3, rnd256(), o);
    chk("simul_first_i", 256'(o), 256'(0));
    xfer(1'b0, 1'b0, 1, rnd256(), o);
    chk("simul_second_d", 256'(o), 256'(1));

    // Both requesting continuously: strict alternation
    for (int t = 0; t < 6; t++) begin
      xfer(1'b1, 1'b1, int'($urandom_range(0, 4)), rnd256(), o);
      chk("rr_order", 256'(o), 256'(t % 2));
    end
    if (pend_i) xfer(1'b0, 1'b0, 1, rnd256(), o);
    if (pend_d) xfer(1'b0, 1'b0, 1, rnd256(), o);

    // Writeback
    pend_d = 1'b1; a_d = 32'h134; wr_d = 1'b1;
    for (int k = 0; k < 32; k++) wd_d[k*8 +: 8] = 8'hA5;
    xfer(1'b0, 1'b0, 4, rnd256(), o);
    chk("wb_owner", 256'(o), 256'(1));

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      bit ni, nd;
      ni = 1'($urandom_range(0, 1));
      nd = 1'($urandom_range(0, 1));
      if (!pend_i && !pend_d && !ni && !nd) ni = 1'b1;
      xfer(ni, nd, int'($urandom_range(0, 5)), rnd256(), o);
    end

    // d_read and d_write together: handled as a write, flagged
    do_reset();
    bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_addr = 32'h300; wd_d = rnd256(); bus.d_wdata = wd_d;
    tick();
    chk("rw_both_cmd", 256'({bus.l2_read, bus.l2_write}), 256'(1));
    chk("rw_both_wdata", bus.l2_wdata, wd_d);
    chk("rw_both_proto", 256'(bus.err_proto), 256'(1));
    bus.l2_resp = 1'b1; #1;
    chk("rw_both_resp", 256'(bus.d_resp), 256'(1));
    tick();
    bus.l2_resp = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;

    // Owner drops its request mid-transfer
    do_reset();
    bus.d_read = 1'b1; bus.d_addr = 32'h200;
    tick();
    chk("drop_grant", 256'({bus.l2_read, bus.l2_write, bus.l2_addr}), 256'({2'b10, 32'h200}));
    tick();
    bus.d_read = 1'b0;
    tick();
    chk("drop_proto", 256'(bus.err_proto), 256'(1));
    chk("drop_still_busy", 256'(bus.l2_read), 256'(1));
    rd = rnd256(); bus.l2_rdata = rd; bus.l2_resp = 1'b1; #1;
    chk("drop_complete", 256'({bus.i_resp, bus.d_resp}), 256'(1));
    chk("drop_rdata", bus.d_rdata, rd);
    tick();
    bus.l2_resp = 1'b0;
    chk("drop_cmd_cleared", 256'(bus.l2_read), 256'(0));

    // Silent L2: watchdog fires after TIMEOUT busy cycles
    do_reset();
    bus.i_read = 1'b1; bus.i_addr = 32'h400;
    tick();
    chk("tmo_grant", 256'(bus.l2_read), 256'(1));
    repeat (TIMEOUT - 1) tick();
    chk("tmo_not_yet", 256'(bus.err_timeout), 256'(0));
    tick();
    chk("tmo_set", 256'(bus.err_timeout), 256'(1));
    chk("tmo_still_waiting", 256'({bus.l2_read, bus.l2_addr}), 256'({1'b1, 32'h400}));
    bus.l2_resp = 1'b1; #1;
    chk("tmo_resp", 256'(bus.i_resp), 256'(1));
    tick();
    bus.l2_resp = 1'b0; bus.i_read = 1'b0;
    chk("tmo_sticky", 256'(bus.err_timeout), 256'(1));

    // Asynchronous reset in the middle of a writeback
    do_reset();
    bus.d_write = 1'b1; bus.d_addr = 32'h500; bus.d_wdata = rnd256();
    tick();
    chk("areset_grant", 256'(bus.l2_write), 256'(1));
    tick();
    #2;
    rst_n = 1'b0;
    bus.l2_resp = 1'b1;
    #1;
    chk("areset_l2_cmd", 256'({bus.l2_read, bus.l2_write}), 256'(0));
    chk("areset_l2_addr", 256'(bus.l2_addr), 256'(0));
    chk("areset_resp_idle", 256'({bus.i_resp, bus.d_resp}), 256'(0));
    bus.l2_resp = 1'b0; bus.d_write = 1'b0;
    bus.i_read = 1'b1; bus.i_addr = 32'h600;
    rst_n = 1'b1;
    tick();
    chk("areset_idle_regrant", 256'({bus.l2_read, bus.l2_write, bus.l2_addr}), 256'({2'b10, 32'h600}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
